// File: rtl/pdp1_operand_unit_pkg.sv
// pdp1_operand_unit_pkg: opcodes, FSM state codes and opcode classes used by the operand stage.
package pdp1_operand_unit_pkg;

    localparam logic [0:4] OP_AND = 5'o01;
    localparam logic [0:4] OP_IOR = 5'o02;
    localparam logic [0:4] OP_XOR = 5'o03;
    localparam logic [0:4] OP_ADD = 5'o20;
    localparam logic [0:4] OP_SUB = 5'o21;
    localparam logic [0:4] OP_IDX = 5'o22;
    localparam logic [0:4] OP_ISP = 5'o23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEFER,
        S_FETCH,
        S_EXEC,
        S_STORE,
        S_DONE
    } of_state_t;

    function automatic logic op_legal(input logic [0:4] op);
        return op inside {OP_AND, OP_IOR, OP_XOR, OP_ADD, OP_SUB, OP_IDX, OP_ISP};
    endfunction

    function automatic logic op_stores(input logic [0:4] op);
        return op == OP_ISP || op == OP_IDX;
    endfunction

    function automatic logic op_arith(input logic [0:4] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

endpackage

// File: rtl/pdp1_operand_unit.sv
// pdp1_operand_unit: resolves the defer chain, fetches the operand, drives the ALU and
// retires the result to AC and, for ISP/IDX, back to memory.
module pdp1_operand_unit
    import pdp1_operand_unit_pkg::*;
#(
    parameter string pdp_model = "PDP-1D",
    parameter int    MAX_DEFER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        of_start,
    input  logic [0:4]  of_op,
    input  logic        of_ind,
    input  logic [0:11] of_y,
    input  logic [0:17] of_ac,
    output logic        of_busy,
    output logic        of_done,
    output logic        of_err,
    output logic        of_ac_we,
    output logic [0:17] of_ac_wd,
    output logic        of_ovfl_set,
    output logic        of_skip,
    output logic [0:11] mm_addr,
    output logic        mm_rd,
    output logic        mm_wr,
    output logic [0:17] mm_wdata,
    input  logic [0:17] mm_rdata,
    input  logic        mm_ack,
    output logic [0:4]  al_op,
    output logic [0:17] al_a,
    output logic [0:17] al_b,
    input  logic [0:17] al_r,
    input  logic        al_ovfl,
    input  logic        al_w
);

    localparam bit multi = (pdp_model == "PDP-1D");

    of_state_t   state;
    logic [0:4]  op;
    logic [0:17] ac;
    logic [3:0]  cnt;
    logic        defer_more, defer_err, go_done, done_err, ok;
    logic [0:17] fin_r;

    // Every path into DONE funnels through go_done so the strobes are computed in one place;
    // a stored result is still held in mm_wdata when STORE completes.
    always_comb begin
        defer_more = multi && mm_rdata[5];
        defer_err  = defer_more && cnt == 4'(MAX_DEFER - 1);
        go_done    = (state == S_IDLE && of_start && !op_legal(of_op)) ||
                     (state == S_DEFER && mm_ack && defer_err) ||
                     (state == S_EXEC && (!al_w || !op_stores(op))) ||
                     (state == S_STORE && mm_ack);
        done_err   = state != S_STORE && !(state == S_EXEC && al_w);
        ok         = go_done && !done_err;
        fin_r      = (state == S_EXEC) ? al_r : mm_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op          <= '0;
            ac          <= '0;
            cnt         <= '0;
            of_busy     <= 1'b0;
            of_done     <= 1'b0;
            of_err      <= 1'b0;
            of_ac_we    <= 1'b0;
            of_ac_wd    <= '0;
            of_ovfl_set <= 1'b0;
            of_skip     <= 1'b0;
            mm_addr     <= '0;
            mm_rd       <= 1'b0;
            mm_wr       <= 1'b0;
            mm_wdata    <= '0;
            al_op       <= '0;
            al_a        <= '0;
            al_b        <= '0;
        end else begin
            of_done     <= go_done;
            of_err      <= go_done && done_err;
            of_ac_we    <= ok;
            of_ac_wd    <= ok ? fin_r : '0;
            of_ovfl_set <= ok && op_arith(op) && al_ovfl;
            of_skip     <= ok && op == OP_ISP && !fin_r[0];
            al_op       <= '0;
            al_a        <= '0;
            al_b        <= '0;
            if (go_done) begin
                state   <= S_DONE;
                of_busy <= 1'b1;
                mm_rd   <= 1'b0;
                mm_wr   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (of_start) begin
                        op      <= of_op;
                        ac      <= of_ac;
                        mm_addr <= of_y;
                        cnt     <= '0;
                        of_busy <= 1'b1;
                        mm_rd   <= 1'b1;
                        state   <= of_ind ? S_DEFER : S_FETCH;
                    end
                    S_DEFER: if (mm_ack) begin
                        mm_addr <= mm_rdata[6:17];
                        cnt     <= cnt + 4'd1;
                        state   <= defer_more ? S_DEFER : S_FETCH;
                    end
                    S_FETCH: if (mm_ack) begin
                        mm_rd <= 1'b0;
                        al_op <= op;
                        al_a  <= ac;
                        al_b  <= mm_rdata;
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        mm_wr    <= 1'b1;
                        mm_wdata <= al_r;
                        state    <= S_STORE;
                    end
                    S_STORE: ;
                    S_DONE: begin
                        of_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdp1_operand_unit.sv
// tb_pdp1_operand_unit: random and directed operations against a memory/ALU model; a monitor
// checks each completion against the reference prediction queued when the operation was issued.
module tb_pdp1_operand_unit;

    localparam int MAXD = 8;

    logic        clk = 0, rst_n = 1;
    logic        of_start = 0, of_ind = 0;
    logic [0:4]  of_op = 0;
    logic [0:11] of_y = 0;
    logic [0:17] of_ac = 0;
    logic        of_busy, of_done, of_err, of_ac_we, of_ovfl_set, of_skip;
    logic [0:17] of_ac_wd;
    logic [0:11] mm_addr;
    logic        mm_rd, mm_wr;
    logic [0:17] mm_wdata;
    logic [0:17] mm_rdata = 0;
    logic        mm_ack = 0;
    logic [0:4]  al_op;
    logic [0:17] al_a, al_b, al_r;
    logic        al_ovfl, al_w;

    logic [0:17] mem [4096];
    int          vectors = 0, errors = 0, cyc = 0, c0 = 0, waits = 0, wait_pct = 0, ndone = 0;
    bit          alu_fail = 0, block_wr = 0, wrote = 0, req_seen = 0, stalled = 0;
    logic [0:11] waddr = 0, hold_addr = 0;
    logic [0:17] wdata = 0;

    typedef struct {
        bit          err, we, ov, sk, st, req;
        logic [0:17] wd, sd;
        logic [0:11] sa;
        int          lat;
    } exp_t;
    exp_t sb[$];

    pdp1_operand_unit dut (
        .clk(clk), .rst_n(rst_n), .of_start(of_start), .of_op(of_op), .of_ind(of_ind),
        .of_y(of_y), .of_ac(of_ac), .of_busy(of_busy), .of_done(of_done), .of_err(of_err),
        .of_ac_we(of_ac_we), .of_ac_wd(of_ac_wd), .of_ovfl_set(of_ovfl_set), .of_skip(of_skip),
        .mm_addr(mm_addr), .mm_rd(mm_rd), .mm_wr(mm_wr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_ack(mm_ack), .al_op(al_op), .al_a(al_a), .al_b(al_b),
        .al_r(al_r), .al_ovfl(al_ovfl), .al_w(al_w)
    );

    always #5 clk = ~clk;

    // One's complement add with end-around carry; -0 is normalised to +0.
    function automatic logic [18:0] oc_add(input logic [17:0] a, input logic [17:0] b);
        logic [18:0] s;
        logic [17:0] r;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b};
        r  = s[17:0] + {17'd0, s[18]};
        ov = (a[17] == b[17]) && (r[17] != a[17]);
        if (r == 18'o777777) r = '0;
        return {ov, r};
    endfunction

    function automatic logic [18:0] alu(input logic [4:0] op, input logic [17:0] a, input logic [17:0] b);
        case (op)
            5'o01: return {1'b0, a & b};
            5'o02: return {1'b0, a | b};
            5'o03: return {1'b0, a ^ b};
            5'o20: return oc_add(a, b);
            5'o21: return oc_add(a, ~b);
            5'o22, 5'o23: return oc_add(b, 18'd1);
            default: return '0;
        endcase
    endfunction

    always_comb {al_ovfl, al_r} = alu(al_op, al_a, al_b);
    assign al_w = !alu_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o, expected %0o", nm, act, exp);
        end
    endtask

    task automatic responder();
        forever begin
            @(negedge clk);
            mm_ack   = (mm_rd || mm_wr) && !(block_wr && mm_wr) && int'($urandom_range(99)) >= wait_pct;
            mm_rdata = mem[mm_addr];
        end
    endtask

    task automatic tracker();
        forever begin
            @(posedge clk);
            cyc++;
            if (of_start && !of_busy) begin
                waits = 0; wrote = 0; req_seen = 0; stalled = 0;
            end else begin
                if (mm_rd || mm_wr) req_seen = 1;
                stalled = (mm_rd || mm_wr) && !mm_ack;
                if (stalled) begin waits++; hold_addr = mm_addr; end
                if (mm_wr && mm_ack) begin wrote = 1; waddr = mm_addr; wdata = mm_wdata; end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rd_wr_excl", {31'd0, mm_rd && mm_wr}, 0);
                if (stalled && (mm_rd || mm_wr)) chk("addr_stable", mm_addr, hold_addr);
                if (of_done) begin
                    ndone++;
                    if (sb.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("err", of_err, e.err);
                        chk("ac_we", of_ac_we, e.we);
                        if (e.we) chk("ac_wd", of_ac_wd, e.wd);
                        chk("ovfl_set", of_ovfl_set, e.ov);
                        chk("skip", of_skip, e.sk);
                        chk("mem_write", wrote, e.st);
                        if (e.st) begin
                            chk("wr_addr", waddr, e.sa);
                            chk("wr_data", wdata, e.sd);
                        end
                        chk("mem_request", req_seen, e.req);
                        chk("latency", cyc - c0 - waits, e.lat);
                    end
                end
            end
        end
    endtask

    function automatic exp_t predict(input logic [0:4] op, input logic ind, input logic [0:11] y,
                                     input logic [0:17] ac);
        exp_t        e;
        logic [0:11] a;
        logic [0:17] w;
        logic [18:0] r;
        int          n;
        bit          more;
        e = '{default: 0};
        if (!(op inside {5'o01, 5'o02, 5'o03, 5'o20, 5'o21, 5'o22, 5'o23})) begin
            e.err = 1; e.lat = 1;
            return e;
        end
        a = y; n = 0; more = ind; e.req = 1;
        while (more && n < MAXD) begin
            w = mem[a]; n++; a = w[6:17]; more = w[5];
        end
        if (more) begin e.err = 1; e.lat = 1 + n; end
        else if (alu_fail) begin e.err = 1; e.lat = 3 + n; end
        else begin
            r = alu(op, ac, mem[a]);
            e.we = 1; e.wd = r[17:0];
            e.ov = (op == 5'o20 || op == 5'o21) && r[18];
            e.st = (op == 5'o22 || op == 5'o23);
            e.sk = (op == 5'o23) && !r[17];
            e.sa = a; e.sd = r[17:0];
            e.lat = 3 + n + int'(e.st);
        end
        return e;
    endfunction

    task automatic run(input logic [0:4] op, input logic ind, input logic [0:11] y, input logic [0:17] ac);
        bit got = 0;
        sb.push_back(predict(op, ind, y, ac));
        @(negedge clk);
        chk("idle_before_start", of_busy, 0);
        of_op = op; of_ind = ind; of_y = y; of_ac = ac; of_start = 1; c0 = cyc;
        @(negedge clk);
        of_start = 0;
        chk("busy_after_start", of_busy, 1);
        for (int n = 0; n < 400; n++) begin
            if (of_done) begin got = 1; break; end
            of_start = of_busy && $urandom_range(7) == 0;
            of_op = 5'($urandom); of_ind = 1'($urandom); of_y = 12'($urandom); of_ac = 18'($urandom);
            @(negedge clk);
        end
        of_start = 0;
        if (!got) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        if (wrote) mem[waddr] = wdata;
    endtask

    initial begin
        bit got;
        int nd;
        logic [0:4] rop;
        fork responder(); tracker(); monitor(); join_none
        for (int i = 0; i < 4096; i++) mem[i] = 0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", of_busy, 0);
        chk("rst_done", of_done, 0);
        chk("rst_ac_we", of_ac_we, 0);
        chk("rst_mm_rd", mm_rd, 0);
        chk("rst_mm_wr", mm_wr, 0);
        chk("rst_mm_addr", mm_addr, 0);
        chk("rst_al_op", al_op, 0);
        chk("rst_al_a", al_a, 0);
        chk("rst_al_b", al_b, 0);
        rst_n = 1;

        mem[12'o0100] = 18'o000002;  run(5'o20, 0, 12'o0100, 18'o000001);
        mem[12'o0100] = 18'o000001;  run(5'o20, 0, 12'o0100, 18'o377777);
        mem[12'o0200] = 18'o777776;  run(5'o23, 0, 12'o0200, 18'o123456);
        chk("isp_mem_zero", mem[12'o0200], 18'o000000);
        mem[12'o0200] = 18'o000005;  run(5'o23, 0, 12'o0200, 18'o0);
        chk("isp_mem_six", mem[12'o0200], 18'o000006);
        mem[12'o0100] = 18'o000200;  run(5'o21, 1, 12'o0100, 18'o000005);
        for (int i = 0; i < 9; i++) mem[12'o0300 + i] = 18'o010000 | 18'(12'o0301 + i);
        run(5'o20, 1, 12'o0300, 18'o000001);
        for (int i = 0; i < 7; i++) mem[12'o0320 + i] = 18'o010000 | 18'(12'o0321 + i);
        mem[12'o0327] = 18'o000500;  mem[12'o0500] = 18'o000007;
        run(5'o02, 1, 12'o0320, 18'o000070);
        run(5'o04, 0, 12'o0100, 18'o000001);
        alu_fail = 1;  run(5'o22, 0, 12'o0200, 18'o0);  alu_fail = 0;
        chk("alu_fail_no_store", mem[12'o0200], 18'o000006);

        block_wr = 1; mem[12'o0400] = 18'o000005;
        @(negedge clk);
        of_op = 5'o23; of_ind = 0; of_y = 12'o0400; of_start = 1; c0 = cyc;
        @(negedge clk);
        of_start = 0; got = 0;
        for (int n = 0; n < 50; n++) begin
            if (mm_wr) begin got = 1; break; end
            @(negedge clk);
        end
        chk("store_reached", got, 1);
        nd = ndone;
        #1 rst_n = 0;
        #1;
        chk("abort_mm_wr", mm_wr, 0);
        chk("abort_busy", of_busy, 0);
        @(negedge clk);
        rst_n = 1; block_wr = 0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", ndone, nd);
        chk("abort_no_write", wrote, 0);

        for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
        for (int k = 0; k < 200; k++) begin
            wait_pct = $urandom_range(40);
            alu_fail = $urandom_range(19) == 0;
            case ($urandom_range(7))
                0: rop = 5'o01; 1: rop = 5'o02; 2: rop = 5'o03; 3: rop = 5'o20;
                4: rop = 5'o21; 5: rop = 5'o22; 6: rop = 5'o23; default: rop = 5'($urandom);
            endcase
            run(rop, 1'($urandom), 12'($urandom), 18'($urandom));
        end
        wait_pct = 0; alu_fail = 0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
